// File: rtl/fetch.sv
// ---------------------------------------------------------------------------
// fetch -- instruction fetch stage with a single outstanding memory request.
//
// Requests instruction words one at a time from instruction memory and
// presents them to decode on or_inst/or_pc/or_valid. A one-entry hold buffer
// catches a word returned while decode is stalled. A flush redirects the
// fetch stream; a request still outstanding at flush time is completed and
// its data thrown away (DROP state) so the memory handshake stays intact.
//
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   defined   : a redirect with pc[1:0] != 0 pulses or_misaligned for one
//               cycle and parks the fetcher in IDLE until an aligned flush.
//   undefined : or_misaligned is absent and redirect pc[1:0] is forced to 0.
//
// Ports
//   i_clk, i_rst_n         clock; synchronous active-low reset
//   o_imem_req/o_imem_addr memory request (held until ack) and its address
//   i_imem_ack/i_imem_data memory response and instruction word
//   i_stall                decode cannot accept; or_* are held
//   i_flush/i_redirect_pc  redirect fetch to a new pc
//   or_inst/or_pc/or_valid instruction presented to decode
//   or_misaligned          misaligned redirect pulse (macro builds only)
// ---------------------------------------------------------------------------
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_data,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic [31:0] i_redirect_pc,
  output logic [31:0] or_inst,
  output logic [31:0] or_pc,
  output logic        or_valid
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        or_misaligned
`endif
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;          // next fetch pc (redirect target while in DROP)
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] opc_q, opc_d;
  logic        valid_q, valid_d;
  logic [31:0] hbuf_inst_q, hbuf_inst_d;
  logic [31:0] hbuf_pc_q, hbuf_pc_d;
  logic [31:0] redir_s;
  logic        outstanding_s;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misal_q, misal_d;
  logic        trap_q, trap_d;    // parked after a misaligned redirect
  logic        misredir_s;
`endif

  assign o_imem_req  = req_q;
  assign o_imem_addr = addr_q;
  assign or_inst     = inst_q;
  assign or_pc       = opc_q;
  assign or_valid    = valid_q;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign or_misaligned = misal_q;
`endif

  // Redirect target and whether a request is still unanswered this cycle.
  always_comb begin
`ifdef FETCH_MISALIGN_TRAP_EN
    redir_s    = i_redirect_pc;
    misredir_s = (i_redirect_pc[1:0] != 2'b00);
`else
    redir_s    = {i_redirect_pc[31:2], 2'b00};
`endif
    outstanding_s = ((state_q == REQ) || (state_q == DROP)) && !i_imem_ack;
  end

  // Next-state and next-output logic; flush overrides stall and ack.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_d       = req_q;
    addr_d      = addr_q;
    inst_d      = inst_q;
    opc_d       = opc_q;
    valid_d     = valid_q;
    hbuf_inst_d = hbuf_inst_q;
    hbuf_pc_d   = hbuf_pc_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    misal_d     = 1'b0;
    trap_d      = trap_q;
`endif
    if (i_flush) begin
      inst_d  = NOP;
      opc_d   = 32'h0000_0000;
      valid_d = 1'b0;
      pc_d    = redir_s;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (misredir_s) begin
        misal_d = 1'b1;
        trap_d  = 1'b1;
        state_d = IDLE;
        req_d   = 1'b0;
      end else begin
        trap_d = 1'b0;
`endif
        // An unanswered request must still complete; its data is dropped.
        if (outstanding_s) begin
          state_d = DROP;
        end else begin
          state_d = REQ;
          req_d   = 1'b1;
          addr_d  = redir_s;
        end
`ifdef FETCH_MISALIGN_TRAP_EN
      end
`endif
    end else begin
      case (state_q)
        IDLE: begin
`ifdef FETCH_MISALIGN_TRAP_EN
          if (trap_q) begin
            state_d = IDLE;
          end else begin
            state_d = REQ;
            req_d   = 1'b1;
            addr_d  = pc_q;
          end
`else
          state_d = REQ;
          req_d   = 1'b1;
          addr_d  = pc_q;
`endif
        end
        REQ: begin
          if (i_imem_ack && i_stall) begin
            hbuf_inst_d = i_imem_data;
            hbuf_pc_d   = addr_q;
            req_d       = 1'b0;
            state_d     = HOLD;
          end else if (i_imem_ack) begin
            inst_d  = i_imem_data;
            opc_d   = addr_q;
            valid_d = 1'b1;
            pc_d    = addr_q + 32'd4;
            addr_d  = addr_q + 32'd4;
          end else if (!i_stall) begin
            // Decode consumed the previous word and nothing new arrived.
            valid_d = 1'b0;
          end else begin
            valid_d = valid_q;
          end
        end
        HOLD: begin
          if (!i_stall) begin
            inst_d  = hbuf_inst_q;
            opc_d   = hbuf_pc_q;
            valid_d = 1'b1;
            pc_d    = hbuf_pc_q + 32'd4;
            addr_d  = hbuf_pc_q + 32'd4;
            req_d   = 1'b1;
            state_d = REQ;
          end else begin
            state_d = HOLD;
          end
        end
        DROP: begin
          if (i_imem_ack) begin
            state_d = REQ;
            addr_d  = pc_q;
          end else begin
            state_d = DROP;
          end
        end
        default: begin
          state_d = IDLE;
          req_d   = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      req_q       <= 1'b0;
      addr_q      <= RESET_PC;
      inst_q      <= NOP;
      opc_q       <= 32'h0000_0000;
      valid_q     <= 1'b0;
      hbuf_inst_q <= 32'h0000_0000;
      hbuf_pc_q   <= 32'h0000_0000;
`ifdef FETCH_MISALIGN_TRAP_EN
      misal_q     <= 1'b0;
      trap_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      inst_q      <= inst_d;
      opc_q       <= opc_d;
      valid_q     <= valid_d;
      hbuf_inst_q <= hbuf_inst_d;
      hbuf_pc_q   <= hbuf_pc_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      misal_q     <= misal_d;
      trap_q      <= trap_d;
`endif
    end
  end

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, first instruction address after reset.
REQ-002 i_clk  in  1  CPU clock; all state updates on rising edge.
REQ-003 i_rst_n  in  1  reset, synchronous, active-low.
REQ-004 o_imem_req  out  1  instruction memory request; held high until ack.
REQ-005 o_imem_addr  out  32  fetch address; stable while o_imem_req high.
REQ-006 i_imem_ack  in  1  memory response valid; earliest one cycle after req rises.
REQ-007 i_imem_data  in  32  instruction word, valid with i_imem_ack.
REQ-008 i_stall  in  1  decode cannot accept; hold outputs.
REQ-009 i_flush  in  1  redirect fetch; squash in-flight and buffered instructions.
REQ-010 i_redirect_pc  in  32  new fetch address, sampled with i_flush.
REQ-011 or_inst  out  32  instruction to decode.
REQ-012 or_pc  out  32  address of or_inst.
REQ-013 or_valid  out  1  or_inst/or_pc hold a real instruction.
REQ-014 or_misaligned  out  1  misaligned redirect flag; present only with FETCH_MISALIGN_TRAP_EN.

Function
REQ-015 SHALL implement FSM states IDLE, REQ, HOLD, DROP; one outstanding request maximum.
REQ-016 IDLE: o_imem_req=0; SHALL enter REQ the cycle after reset release, o_imem_addr=pc.
REQ-017 REQ: o_imem_req=1; on ack with no stall/flush -> or_inst<=data, or_pc<=addr, or_valid<=1, pc<=addr+4, remain REQ with new address next cycle.
REQ-018 Latency: ack in cycle N -> or_inst valid in cycle N+1; sustained throughput one instruction per cycle with single-cycle memory.
REQ-019 Ack while i_stall=1: SHALL capture data/addr in a one-entry hold buffer, keep or_* unchanged, deassert o_imem_req, enter HOLD.
REQ-020 HOLD: when i_stall falls, SHALL move buffer to or_*, advance pc, enter REQ next cycle.
REQ-021 Stall without ack: or_* held, request stays asserted with unchanged address.
REQ-022 i_flush has priority over i_stall and ack in all states.
REQ-023 On flush: pc<=i_redirect_pc (bits[1:0] per REQ-031/032); or_inst<=32'h0000_0013 (NOP), or_pc<=0, or_valid<=0.
REQ-024 Flush in REQ without same-cycle ack: SHALL enter DROP, keep o_imem_req high at old address until ack, discard that data, then REQ at redirect pc.
REQ-025 Flush in REQ with same-cycle ack, or in HOLD: data/buffer discarded, enter REQ at redirect pc next cycle.
REQ-026 Flush in DROP: latest redirect pc replaces earlier one; remain DROP.
REQ-027 PC arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-028 Ack outside REQ/DROP SHALL be ignored.

Reset
REQ-029 i_rst_n=0 at clock edge: pc<=RESET_PC, state<=IDLE, o_imem_req<=0, o_imem_addr<=RESET_PC, or_inst<=NOP, or_pc<=0, or_valid<=0, hold buffer cleared, or_misaligned<=0.
REQ-030 Reset mid-request SHALL abandon the transaction; a late ack after reset release, before first new req, is ignored.

Configuration
REQ-031 With FETCH_MISALIGN_TRAP_EN defined: redirect with i_redirect_pc[1:0]!=0 SHALL pulse or_misaligned for one cycle, hold state IDLE with no request until next flush with aligned pc.
REQ-032 Without FETCH_MISALIGN_TRAP_EN: or_misaligned port absent; i_redirect_pc[1:0] forced to 2'b00 silently.

Verification
REQ-033 Reset release, RESET_PC=0, memory acks every cycle -> or_pc sequence 0,4,8,... from cycle 2, or_valid=1.
REQ-034 i_stall high 3 cycles during ack of addr 0x10 -> or_* frozen, req low, then or_pc=0x10 one cycle after stall falls; no instruction lost or duplicated.
REQ-035 Flush to 0x200 while req to 0x20 pending, ack 2 cycles later -> that data discarded, or_valid=0 meanwhile, next or_pc=0x200.
REQ-036 Flush+stall+ack same cycle -> NOP output, or_valid=0, next request address = redirect pc.
REQ-037 Start at 0xFFFF_FFFC -> next or_pc 0x0000_0000.
REQ-038 Redirect to 0x102: with macro -> or_misaligned one-cycle pulse, no request; without -> fetch from 0x100.
